// File: rtl/bus_ic_pkg.sv
// Shared definitions for the shared-bus interconnect: FSM encodings,
// response codes, the chip memory map and a width helper.
package bus_ic_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_XFER = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam logic RESP_OK  = 1'b0;
   localparam logic RESP_ERR = 1'b1;

   // Slave 0 (SRAM) in the LSBs, then UART, GPIO, PMU, FLASH.
   localparam logic [5*32-1:0] DEF_SLV_BASE = {
      32'h2000_0000, 32'h1000_2000, 32'h1000_1000,
      32'h1000_0000, 32'h0000_0000
   };
   localparam logic [5*32-1:0] DEF_SLV_MASK = {
      32'hFF00_0000, 32'hFFFF_FFF0, 32'hFFFF_FFF0,
      32'hFFFF_FFF0, 32'hFFF0_0000
   };

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/bus_interconnect_arb.sv
// Combinational round-robin arbiter with a lock override that lets
// the previous owner keep the bus while it still requests.
module rr_arbiter
   import bus_ic_pkg::*;
#(
   parameter int N  = 2,
   parameter int IW = 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   input  logic          lock_hold_i,
   input  logic [IW-1:0] lock_idx_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o,
   output logic          valid_o
);

   always_comb begin
      logic [IW-1:0] j;
      j = '0;
      idx_o = '0;
      // Walk from the farthest slot back so the nearest requester wins.
      for (int k = N; k >= 1; k--) begin
         j = IW'((int'(ptr_i) + k) % N);
         if (req_i[j]) idx_o = j;
      end
      if (lock_hold_i && req_i[lock_idx_i]) idx_o = lock_idx_i;
      valid_o = |req_i;
      gnt_o = '0;
      gnt_o[idx_o] = valid_o;
   end

endmodule

// File: rtl/bus_interconnect.sv
// N-master / M-slave shared bus: round-robin grant with lock, base/mask
// decode, slave wait states and decode-miss / timeout error responses.
module bus_interconnect
   import bus_ic_pkg::*;
#(
   parameter int N_MASTERS = 2,
   parameter int N_SLAVES  = 5,
   parameter int AW        = 32,
   parameter int DW        = 32,
   parameter logic [N_SLAVES*AW-1:0] SLV_BASE = DEF_SLV_BASE,
   parameter logic [N_SLAVES*AW-1:0] SLV_MASK = DEF_SLV_MASK,
   parameter int TIMEOUT   = 255
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [N_MASTERS-1:0]        m_req,
   input  logic [N_MASTERS-1:0]        m_lock,
   input  logic [N_MASTERS-1:0]        m_we,
   input  logic [N_MASTERS*AW-1:0]     m_addr,
   input  logic [N_MASTERS*DW-1:0]     m_wdata,
   input  logic [N_MASTERS*DW/8-1:0]   m_be,
   output logic [DW-1:0]               m_rdata,
   output logic [N_MASTERS-1:0]        m_ready,
   output logic                        m_err,
   output logic [N_SLAVES-1:0]         s_sel,
   output logic                        s_we,
   output logic [AW-1:0]               s_addr,
   output logic [DW-1:0]               s_wdata,
   output logic [DW/8-1:0]             s_be,
   input  logic [N_SLAVES*DW-1:0]      s_rdata,
   input  logic [N_SLAVES-1:0]         s_ready,
   output logic [clog2(N_MASTERS)-1:0] owner,
   output logic                        busy
);

   localparam int IW = clog2(N_MASTERS);
   localparam int BW = DW / 8;

   logic [1:0]          state_q, state_d;
   logic [IW-1:0]       owner_q, ptr_q;
   logic [15:0]         cnt_q;
   logic                lock_q;
   logic [N_SLAVES-1:0] sel_q;
   logic                we_q;
   logic [AW-1:0]       addr_q;
   logic [DW-1:0]       wdata_q, rdata_q;
   logic [BW-1:0]       be_q;
   logic                err_q;

   logic [N_MASTERS-1:0] gnt;
   logic [IW-1:0]        gidx;
   logic                 gnt_vld;
   logic [AW-1:0]        g_addr;
   logic [DW-1:0]        g_wdata;
   logic [BW-1:0]        g_be;
   logic                 g_we;
   logic [N_SLAVES-1:0]  dec_sel;
   logic                 dec_hit;
   logic                 slv_rdy, tmo;
   logic [DW-1:0]        sel_rdata;

   rr_arbiter #(.N(N_MASTERS), .IW(IW)) u_arb (
      .req_i       (m_req),
      .ptr_i       (ptr_q),
      .lock_hold_i (lock_q && (state_q == ST_IDLE)),
      .lock_idx_i  (owner_q),
      .gnt_o       (gnt),
      .idx_o       (gidx),
      .valid_o     (gnt_vld)
   );

   always_comb begin
      g_addr = '0;
      g_wdata = '0;
      g_be = '0;
      g_we = 1'b0;
      for (int i = 0; i < N_MASTERS; i++) begin
         if (gnt[i]) begin
            g_addr  = m_addr[i*AW +: AW];
            g_wdata = m_wdata[i*DW +: DW];
            g_be    = m_be[i*BW +: BW];
            g_we    = m_we[i];
         end
      end
   end

   // Scan downwards so the lowest matching slave index wins on overlap.
   always_comb begin
      dec_sel = '0;
      for (int i = N_SLAVES - 1; i >= 0; i--) begin
         if ((g_addr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]) begin
            dec_sel = '0;
            dec_sel[i] = 1'b1;
         end
      end
      dec_hit = |dec_sel;
   end

   always_comb begin
      sel_rdata = '0;
      for (int i = 0; i < N_SLAVES; i++) begin
         if (sel_q[i]) sel_rdata |= s_rdata[i*DW +: DW];
      end
      slv_rdy = |(sel_q & s_ready);
      tmo = (cnt_q == 16'(TIMEOUT - 1));
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (gnt_vld) state_d = dec_hit ? ST_XFER : ST_RESP;
         ST_XFER: if (slv_rdy || tmo) state_d = ST_RESP;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         owner_q <= '0;
         ptr_q   <= IW'(N_MASTERS - 1);
         cnt_q   <= '0;
         lock_q  <= 1'b0;
         sel_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         rdata_q <= '0;
         err_q   <= RESP_OK;
      end else begin
         state_q <= state_d;
         lock_q  <= (state_q == ST_RESP) && m_lock[owner_q];
         unique case (state_q)
            ST_IDLE: begin
               if (gnt_vld) begin
                  owner_q <= gidx;
                  ptr_q   <= gidx;
                  addr_q  <= g_addr;
                  wdata_q <= g_wdata;
                  be_q    <= g_be;
                  we_q    <= g_we & dec_hit;
                  sel_q   <= dec_sel;
                  cnt_q   <= '0;
                  if (!dec_hit) begin
                     err_q   <= RESP_ERR;
                     rdata_q <= '0;
                  end
               end
            end
            ST_XFER: begin
               cnt_q <= cnt_q + 16'd1;
               if (slv_rdy || tmo) begin
                  sel_q   <= '0;
                  we_q    <= 1'b0;
                  err_q   <= slv_rdy ? RESP_OK : RESP_ERR;
                  rdata_q <= (slv_rdy && !we_q) ? sel_rdata : '0;
               end
            end
            default: cnt_q <= '0;
         endcase
      end
   end

   always_comb begin
      m_ready = '0;
      for (int i = 0; i < N_MASTERS; i++) begin
         m_ready[i] = (state_q == ST_RESP) && (owner_q == IW'(i));
      end
   end

   assign m_rdata = rdata_q;
   assign m_err   = err_q;
   assign s_sel   = sel_q;
   assign s_we    = we_q;
   assign s_addr  = addr_q;
   assign s_wdata = wdata_q;
   assign s_be    = be_q;
   assign owner   = owner_q;
   assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bus_interconnect.sv
// Bench for bus_interconnect: 4 masters, default memory map, TIMEOUT=8;
// transaction-timeline model compared every cycle plus literal checks.
module tb_bus_interconnect;

   localparam int NM = 4;
   localparam int NS = 5;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [NM-1:0]      m_req, m_lock, m_we, m_ready;
   logic [NM*AW-1:0]   m_addr;
   logic [NM*DW-1:0]   m_wdata;
   logic [NM*DW/8-1:0] m_be;
   logic [DW-1:0]      m_rdata;
   logic               m_err;
   logic [NS-1:0]      s_sel, s_ready;
   logic               s_we;
   logic [AW-1:0]      s_addr;
   logic [DW-1:0]      s_wdata;
   logic [DW/8-1:0]    s_be;
   logic [NS*DW-1:0]   s_rdata;
   logic [1:0]         owner;
   logic               busy;

   bus_interconnect #(
      .N_MASTERS(NM), .N_SLAVES(NS), .AW(AW), .DW(DW), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .m_req(m_req), .m_lock(m_lock), .m_we(m_we), .m_addr(m_addr),
      .m_wdata(m_wdata), .m_be(m_be), .m_rdata(m_rdata),
      .m_ready(m_ready), .m_err(m_err),
      .s_sel(s_sel), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
      .s_be(s_be), .s_rdata(s_rdata), .s_ready(s_ready),
      .owner(owner), .busy(busy)
   );

   logic [AW-1:0] base_t [NS] = '{32'h0000_0000, 32'h1000_0000,
                                  32'h1000_1000, 32'h1000_2000,
                                  32'h2000_0000};
   logic [AW-1:0] mask_t [NS] = '{32'hFFF0_0000, 32'hFFFF_FFF0,
                                  32'hFFFF_FFF0, 32'hFFFF_FFF0,
                                  32'hFF00_0000};

   logic [AW-1:0] ma [NM];
   logic [DW-1:0] mw [NM];
   logic [3:0]    mb [NM];
   logic          mwe [NM];
   int            want [NM];
   int            got [NM];
   int            lat [NS];
   logic [DW-1:0] sd [NS];
   int            scnt [NS];
   int            selhigh [NS];
   logic          noise;
   int            cyc = 0;
   int            order [$];
   int            last_cyc;
   logic [DW-1:0] last_rdata;
   logic          last_err;
   int            n_chk = 0;
   int            n_fail = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   always_comb begin
      m_addr = '0;
      m_wdata = '0;
      m_be = '0;
      m_we = '0;
      m_req = '0;
      for (int i = 0; i < NM; i++) begin
         m_addr[i*AW +: AW] = ma[i];
         m_wdata[i*DW +: DW] = mw[i];
         m_be[i*4 +: 4] = mb[i];
         m_we[i] = mwe[i];
         m_req[i] = (want[i] != got[i]);
      end
      s_rdata = '0;
      s_ready = '0;
      for (int s = 0; s < NS; s++) begin
         s_rdata[s*DW +: DW] = sd[s];
         s_ready[s] = (s_sel[s] && scnt[s] == lat[s]) ||
                      (noise && !s_sel[s]);
      end
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int s = 0; s < NS; s++) scnt[s] <= s_sel[s] ? scnt[s] + 1 : 0;
   end

   // Master agents: a master requests while it has outstanding work.
   always @(negedge clk) begin
      for (int i = 0; i < NM; i++) begin
         if (m_ready[i]) begin
            got[i]++;
            order.push_back(i);
            last_cyc = cyc;
            last_rdata = m_rdata;
            last_err = m_err;
         end
      end
      for (int s = 0; s < NS; s++) if (s_sel[s]) selhigh[s]++;
   end

   // Model: one transaction at a time, laid out as a timeline after grant.
   // t=1..n: slave selected, t=n+1: response, then one idle cycle.
   logic          act = 1'b0;
   int            t = 0, n = 0, ptr_m = NM - 1, e_own = 0, s_m = 0;
   logic          lockp = 1'b0, hit_m = 1'b0, we_m = 1'b0, err_m = 1'b0;
   logic [AW-1:0] a_m = '0;
   logic [DW-1:0] w_m = '0, rd_m = '0;
   logic [3:0]    b_m = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act = 1'b0; t = 0; n = 0; ptr_m = NM - 1; e_own = 0; s_m = 0;
         lockp = 1'b0; hit_m = 1'b0; we_m = 1'b0; err_m = 1'b0;
         a_m = '0; w_m = '0; rd_m = '0; b_m = '0;
      end else begin : step
         logic lk;
         int   pick;
         lk = 1'b0;
         pick = -1;
         if (act) begin
            if (t == n + 1) begin
               act = 1'b0;
               lk = m_lock[e_own];
            end else begin
               t++;
            end
         end else if (m_req != '0) begin
            if (lockp && m_req[e_own]) pick = e_own;
            for (int k = 1; k <= NM; k++)
               if (pick < 0 && m_req[(ptr_m + k) % NM]) pick = (ptr_m + k) % NM;
            e_own = pick;
            ptr_m = pick;
            a_m = ma[pick];
            w_m = mw[pick];
            b_m = mb[pick];
            we_m = mwe[pick];
            s_m = -1;
            for (int i = 0; i < NS; i++)
               if (s_m < 0 && (a_m & mask_t[i]) == base_t[i]) s_m = i;
            hit_m = (s_m >= 0);
            rd_m = '0;
            if (!hit_m) begin
               n = 0; err_m = 1'b1;
            end else if (lat[s_m] < TO) begin
               n = lat[s_m] + 1; err_m = 1'b0;
               if (!we_m) rd_m = sd[s_m];
            end else begin
               n = TO; err_m = 1'b1;
            end
            act = 1'b1;
            t = 1;
         end
         lockp = lk;
      end
   end

   logic [NS-1:0] es;
   logic [NM-1:0] er;
   always @(negedge clk) begin
      es = (act && hit_m && t <= n) ? (NS'(1) << s_m) : '0;
      er = (act && t == n + 1) ? (NM'(1) << e_own) : '0;
      chk("busy", busy, act);
      chk("owner", owner, e_own);
      chk("s_sel", s_sel, es);
      chk("s_we", s_we, (es != '0) && we_m);
      chk("m_ready", m_ready, er);
      if (act) begin
         chk("s_addr", s_addr, a_m);
         chk("s_wdata", s_wdata, w_m);
         chk("s_be", s_be, b_m);
      end
      if (er != '0) begin
         chk("m_err", m_err, err_m);
         chk("m_rdata", m_rdata, rd_m);
      end
   end

   function automatic logic all_done();
      logic d;
      d = 1'b1;
      for (int i = 0; i < NM; i++) if (want[i] != got[i]) d = 1'b0;
      return d;
   endfunction

   task automatic wait_all(input int maxc);
      int c;
      c = 0;
      while (!all_done() && c < maxc) begin
         @(posedge clk);
         c++;
      end
      chk("wait_done", all_done(), 1);
      @(posedge clk);
      #2;
   endtask

   task automatic clr_sel();
      for (int s = 0; s < NS; s++) selhigh[s] = 0;
   endtask

   task automatic rst_lits(input string nm);
      chk({nm, "_busy"}, busy, 0);
      chk({nm, "_sel"}, s_sel, 0);
      chk({nm, "_we"}, s_we, 0);
      chk({nm, "_addr"}, s_addr, 0);
      chk({nm, "_ready"}, m_ready, 0);
      chk({nm, "_err"}, m_err, 0);
      chk({nm, "_rdata"}, m_rdata, 0);
      chk({nm, "_owner"}, owner, 0);
   endtask

   int exp_rr [6] = '{0, 1, 2, 3, 0, 1};
   int exp_lk [4] = '{2, 2, 2, 0};
   int ic;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      noise = 1'b0;
      m_lock = '0;
      for (int i = 0; i < NM; i++) begin
         ma[i] = '0; mw[i] = '0; mb[i] = '0; mwe[i] = 1'b0;
         want[i] = 0; got[i] = 0;
      end
      for (int s = 0; s < NS; s++) begin
         lat[s] = 0; sd[s] = 32'hDEAD_0000 + s; selhigh[s] = 0;
      end
      @(posedge clk);
      #1;
      rst_lits("reset");
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #2;

      // All four masters write SRAM twice: strict 0,1,2,3 rotation.
      for (int i = 0; i < NM; i++) begin
         ma[i] = 32'h0000_0010 + 32'(i * 4);
         mw[i] = 32'hC0DE_0000 + 32'(i);
         mb[i] = 4'hF;
         mwe[i] = 1'b1;
      end
      order.delete();
      for (int i = 0; i < NM; i++) want[i] += 2;
      wait_all(200);
      chk("rr_count", order.size(), 8);
      if (order.size() >= 6)
         for (int k = 0; k < 6; k++) chk("rr_order", order[k], exp_rr[k]);
      chk("wr_rdata", last_rdata, 0);

      // Single zero-wait SRAM read.
      ma[0] = 32'h0000_0100; mwe[0] = 1'b0; sd[0] = 32'h1234_5678;
      clr_sel();
      ic = cyc;
      want[0]++;
      wait_all(50);
      chk("rd_lat", last_cyc - ic, 2);
      chk("rd_data", last_rdata, 32'h1234_5678);
      chk("rd_err", last_err, 0);
      chk("rd_selcyc", selhigh[0], 1);

      // Unmapped read from master 1.
      ma[1] = 32'h3000_0000; mwe[1] = 1'b0;
      clr_sel();
      ic = cyc;
      want[1]++;
      wait_all(50);
      chk("miss_lat", last_cyc - ic, 1);
      chk("miss_err", last_err, 1);
      chk("miss_data", last_rdata, 0);
      chk("miss_nosel", selhigh[0] + selhigh[1] + selhigh[2] +
                        selhigh[3] + selhigh[4], 0);

      // Master 2 locks for three transfers while master 0 waits.
      ma[2] = 32'h0000_0200; mwe[2] = 1'b0; lat[0] = 1;
      ma[0] = 32'h0000_0300;
      m_lock[2] = 1'b1;
      order.delete();
      want[2] += 3;
      want[0] += 1;
      wait_all(100);
      m_lock = '0;
      chk("lock_count", order.size(), 4);
      if (order.size() >= 4)
         for (int k = 0; k < 4; k++) chk("lock_order", order[k], exp_lk[k]);

      // UART never answers; unselected slaves assert ready throughout.
      ma[0] = 32'h1000_0004; lat[1] = 1000; noise = 1'b1;
      clr_sel();
      ic = cyc;
      want[0]++;
      wait_all(50);
      noise = 1'b0;
      chk("to_lat", last_cyc - ic, 9);
      chk("to_err", last_err, 1);
      chk("to_data", last_rdata, 0);
      chk("to_selcyc", selhigh[1], 8);

      // GPIO with three wait states after the timeout.
      ma[0] = 32'h1000_1008; lat[2] = 3; sd[2] = 32'hA5A5_5A5A;
      ic = cyc;
      want[0]++;
      wait_all(50);
      chk("ws_lat", last_cyc - ic, 5);
      chk("ws_err", last_err, 0);
      chk("ws_data", last_rdata, 32'hA5A5_5A5A);

      // PMU ready on the very last allowed cycle: ready wins.
      ma[0] = 32'h1000_2000; lat[3] = TO - 1; sd[3] = 32'hBEEF_0003;
      ic = cyc;
      want[0]++;
      wait_all(50);
      chk("edge_lat", last_cyc - ic, 9);
      chk("edge_err", last_err, 0);
      chk("edge_data", last_rdata, 32'hBEEF_0003);

      // Reset in the middle of a FLASH transfer with master 3 pending.
      ma[0] = 32'h2000_0010; lat[4] = 20; sd[4] = 32'hF1A5_0004;
      ma[3] = 32'h0000_0400; mwe[3] = 1'b0; lat[0] = 0;
      want[0]++;
      repeat (3) @(posedge clk);
      #2;
      want[3]++;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      order.delete();
      #1;
      rst_lits("midrst");
      repeat (2) @(posedge clk);
      #2;
      lat[4] = 2;
      rst_n = 1'b1;
      wait_all(100);
      chk("rst_count", order.size(), 2);
      if (order.size() >= 2) begin
         chk("rst_first", order[0], 0);
         chk("rst_second", order[1], 3);
      end

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/bus_interconnect.md
Name: bus_interconnect

Overview:
- Parametrised N-master / M-slave shared-bus interconnect; successor to the fixed two-CPU toggle arbiter in the chip top.
- Adds request/grant handshake with round-robin fairness and slave wait states.
- Adds per-master bus lock, parametrised base/mask address decode, and error responses for decode miss and slave timeout.
- Sits between the CPU cores and the SRAM/UART/GPIO/PMU/flash peripherals.

Parameters:
- N_MASTERS, 2: number of bus masters (2..8).
- N_SLAVES, 5: number of slave ports (1..16).
- AW, 32: address width.
- DW, 32: data width; byte enables are DW/8 wide.
- SLV_BASE, {SRAM 0x00000000, UART 0x10000000, GPIO 0x10001000, PMU 0x10002000, FLASH 0x20000000}: packed N_SLAVES*AW base addresses; slave 0 in the LSBs.
- SLV_MASK, {0xFFF00000, 0xFFFFFFF0, 0xFFFFFFF0, 0xFFFFFFF0, 0xFF000000}: packed N_SLAVES*AW decode masks.
- TIMEOUT, 255: maximum XFER cycles without s_ready before abort (1..65535).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- m_req  in  N_MASTERS  per-master transfer request; held until m_ready.
- m_lock  in  N_MASTERS  keep ownership after the current transfer.
- m_we  in  N_MASTERS  1 = write, 0 = read.
- m_addr  in  N_MASTERS*AW  per-master address.
- m_wdata  in  N_MASTERS*DW  per-master write data.
- m_be  in  N_MASTERS*DW/8  per-master byte enables.
- m_rdata  out  DW  shared read data; valid only with m_ready.
- m_ready  out  N_MASTERS  one-cycle completion pulse to the owner.
- m_err  out  1  error flag, valid with m_ready.
- s_sel  out  N_SLAVES  one-hot slave select.
- s_we  out  1  write strobe to selected slave.
- s_addr  out  AW  address to slaves.
- s_wdata  out  DW  write data to slaves.
- s_be  out  DW/8  byte enables to slaves.
- s_rdata  in  N_SLAVES*DW  per-slave read data.
- s_ready  in  N_SLAVES  per-slave done; sampled only for the selected slave.
- owner  out  clog2(N_MASTERS)  current or last grant index.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; rr pointer=N_MASTERS-1 so master 0 wins first; owner=0. All of s_sel, s_we, s_addr, s_wdata, s_be, m_ready, m_err, m_rdata, busy and the timeout counter are 0. Reset mid-transfer aborts it silently with no m_ready.
- State machine: IDLE, XFER, RESP.
- IDLE, any m_req:
  - Round-robin pick: first requester searching from pointer+1 with wrap.
  - Register owner, pointer=owner, and latch owner's addr/we/wdata/be into the s_* outputs.
  - Decode at latch time: hit = (addr & MASK[i]) == BASE[i]; lowest index wins on overlap.
  - On hit, s_sel one-hot and go to XFER. On miss, s_sel=0 and go directly to RESP with err=1, rdata=0.
- XFER:
  - s_* held stable; counter increments each cycle.
  - If s_ready[sel]: latch s_rdata[sel] (0 for writes) and go to RESP, err=0.
  - Else if counter==TIMEOUT-1: go to RESP, err=1, rdata=0.
  - s_sel and s_we drop on leaving XFER.
- RESP (exactly one cycle):
  - m_ready[owner]=1 with m_rdata and m_err valid; counter cleared.
  - Next state: if m_lock[owner]=1 and m_req[owner] is still high on the following IDLE cycle, owner re-wins regardless of rr order. Otherwise normal rr.
  - RESP always returns to IDLE.
- Latency: req first sampled at edge E → s_sel valid after E+1 → zero-wait slave gives m_ready in cycle E+2 → minimum 3 cycles per transfer, including the IDLE cycle.
- Masters must hold req/addr/data stable until m_ready; changes mid-transfer are ignored because the values are latched.
- Dropping m_req during XFER does not abort the transfer; the response is still delivered.
- Simultaneous requests: exactly one grant; the others wait.
- Fairness: a master waits at most N_MASTERS-1 transfers unless lock is used.
- s_ready for a non-selected slave is ignored.
- s_ready arriving on the same cycle the timeout fires: ready wins, err=0.

Decomposition:
- Package bus_ic_pkg: state enum (IDLE/XFER/RESP), default base/mask constants for the chip memory map, RESP_OK/RESP_ERR codes, clog2 helper.
- Sub-module rr_arbiter (N parameter): inputs req vector, pointer, lock_hold/lock_idx; output one-hot grant plus encoded index; purely combinational. Pointer and state registers live in bus_interconnect.

Test Plan:
- Single master read, SRAM (addr 0x00000100), s_ready immediate with rdata 0x12345678 → s_sel=0b00001 one cycle, m_ready[0] in cycle E+2, m_rdata=0x12345678, m_err=0.
- All masters request SRAM writes every cycle (N_MASTERS=4) → grant order 0,1,2,3,0,1 and each m_ready exactly once per round.
- Master 1 read 0x30000000 (unmapped) → no s_sel, m_ready[1] in cycle E+1, m_err=1, m_rdata=0.
- UART slave never ready, TIMEOUT=8 → s_sel high exactly 8 cycles, then m_ready with m_err=1 and rdata=0. Next request proceeds normally.
- Master 2 holds m_lock=1 for 3 back-to-back transfers while master 0 requests → three consecutive grants to 2, then 0 granted once lock drops.
- Assert rst_n=0 during XFER → all outputs 0 immediately. After release, pending master 0 is granted first and no stale m_ready is produced.
